// File: rtl/capture_sequencer.sv
// Capture sequencer for the OpenADC sample-clock domain.
// Turns the registered arm/trigger/offset/sample/segment/decimation settings
// into the sample FIFO write strobe and the capture status bits. It also
// measures how long the trigger stayed active after the first accepted event.
module capture_sequencer #(
    parameter int pCOUNT_W = 32,
    parameter int pSEG_W   = 16,
    parameter int pCYC_W   = 20,
    parameter int pDS_W    = 13
) (
    input  logic                adc_sampleclk,
    input  logic                reset_i,
    input  logic                cmd_arm_adc,
    input  logic                trig_in,
    input  logic                trigger_mode,
    input  logic                trigger_wait,
    input  logic                trigger_now,
    input  logic [pCOUNT_W-1:0] trigger_offset,
    input  logic [pCOUNT_W-1:0] maxsamples,
    input  logic [pDS_W-1:0]    downsample,
    input  logic [pSEG_W-1:0]   num_segments,
    input  logic [pCYC_W-1:0]   segment_cycles,
    input  logic                segment_cycle_counter_en,
    output logic                sample_en,
    output logic                capturing,
    output logic                armed,
    output logic                capture_done,
    output logic [pSEG_W-1:0]   segment_count,
    output logic [pCOUNT_W-1:0] trigger_length
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_IDLE = 3'd1,
        ST_ARMED     = 3'd2,
        ST_OFFSET    = 3'd3,
        ST_CAPTURE   = 3'd4,
        ST_SEG_WAIT  = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam logic [pSEG_W:0]   SEG_ONE_W = 1;
    localparam logic [pCOUNT_W:0] CNT_ONE_W = 1;
    localparam logic [pCYC_W:0]   CYC_ONE_W = 1;

    state_t              state_q, state_d;
    logic                trig_r_q, trig_r_d;
    logic                rearm_ok_q, rearm_ok_d;
    logic [pCOUNT_W-1:0] offset_q, offset_d;
    logic [pCOUNT_W-1:0] maxs_q, maxs_d;
    logic [pDS_W-1:0]    ds_q, ds_d;
    logic [pCOUNT_W-1:0] off_cnt_q, off_cnt_d;
    logic [pDS_W-1:0]    ds_cnt_q, ds_cnt_d;
    logic [pCOUNT_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [pCYC_W-1:0]   seg_timer_q, seg_timer_d;
    logic [pSEG_W-1:0]   seg_cnt_q, seg_cnt_d;
    logic [pCOUNT_W-1:0] trig_len_q, trig_len_d;
    logic                len_run_q, len_run_d;
    logic                len_started_q, len_started_d;
    logic                sample_en_q, sample_en_d;
    logic                capturing_q, capturing_d;
    logic                armed_q, armed_d;
    logic                done_q, done_d;

    logic                trig_act;
    logic                trig_event;
    logic [pSEG_W-1:0]   seg_limit;
    logic                last_segment;
    logic                last_sample;
    logic                seg_due;
    logic                start_seg;

    assign trig_act     = trigger_mode ? trig_in : ~trig_in;
    assign trig_event   = (trig_act & ~trig_r_q) | trigger_now;
    assign seg_limit    = (num_segments == '0) ? pSEG_W'(1) : num_segments;
    assign last_segment = ({1'b0, seg_cnt_q} + SEG_ONE_W) >= {1'b0, seg_limit};
    assign last_sample  = ({1'b0, samp_cnt_q} + CNT_ONE_W) >= {1'b0, maxs_q};
    // Timer is 0 in the cycle after an event, so this fires segment_cycles after it.
    assign seg_due      = ({1'b0, seg_timer_q} + CYC_ONE_W) >= {1'b0, segment_cycles};

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        state_d       = state_q;
        trig_r_d      = trig_act;
        rearm_ok_d    = cmd_arm_adc ? rearm_ok_q : 1'b1;
        offset_d      = offset_q;
        maxs_d        = maxs_q;
        ds_d          = ds_q;
        off_cnt_d     = off_cnt_q;
        ds_cnt_d      = ds_cnt_q;
        samp_cnt_d    = samp_cnt_q;
        seg_timer_d   = (seg_timer_q == '1) ? seg_timer_q : seg_timer_q + pCYC_W'(1);
        seg_cnt_d     = seg_cnt_q;
        trig_len_d    = trig_len_q;
        len_run_d     = len_run_q;
        len_started_d = len_started_q;
        sample_en_d   = 1'b0;
        start_seg     = 1'b0;

        // Trigger duration runs until the first inactive cycle, saturating.
        if (len_run_q) begin
            if (trig_act) begin
                trig_len_d = (trig_len_q == '1) ? trig_len_q : trig_len_q + pCOUNT_W'(1);
            end else begin
                len_run_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                // Arming needs a fresh arm level after reset or after the last drop.
                if (cmd_arm_adc && rearm_ok_q) begin
                    state_d       = trigger_wait ? ST_WAIT_IDLE : ST_ARMED;
                    seg_cnt_d     = '0;
                    trig_len_d    = '0;
                    len_run_d     = 1'b0;
                    len_started_d = 1'b0;
                    offset_d      = trigger_offset;
                    maxs_d        = (maxsamples == '0) ? pCOUNT_W'(1) : maxsamples;
                    ds_d          = downsample;
                end
            end
            ST_WAIT_IDLE: begin
                if (!trig_act) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (trig_event) begin
                    start_seg = 1'b1;
                end
            end
            ST_OFFSET: begin
                if (off_cnt_q == '0) begin
                    state_d     = ST_CAPTURE;
                    sample_en_d = 1'b1;
                end else begin
                    off_cnt_d = off_cnt_q - pCOUNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (sample_en_q) begin
                    samp_cnt_d = samp_cnt_q + pCOUNT_W'(1);
                    if (last_sample) begin
                        seg_cnt_d = seg_cnt_q + pSEG_W'(1);
                        if (last_segment) begin
                            state_d = ST_DONE;
                        end else if (segment_cycle_counter_en) begin
                            state_d = ST_SEG_WAIT;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        ds_cnt_d    = ds_q;
                        sample_en_d = (ds_q == '0);
                    end
                end else begin
                    ds_cnt_d    = ds_cnt_q - pDS_W'(1);
                    sample_en_d = (ds_cnt_q == pDS_W'(1));
                end
            end
            ST_SEG_WAIT: begin
                if (seg_due) begin
                    start_seg = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A real or synthetic event starts one segment.
        if (start_seg) begin
            state_d     = (offset_q != '0) ? ST_OFFSET : ST_CAPTURE;
            off_cnt_d   = offset_q - pCOUNT_W'(1);
            samp_cnt_d  = '0;
            seg_timer_d = '0;
            sample_en_d = (offset_q == '0);
            if (!len_started_q) begin
                len_started_d = 1'b1;
                len_run_d     = trig_act;
                trig_len_d    = {{(pCOUNT_W-1){1'b0}}, trig_act};
            end
        end

        // Dropping arm abandons everything but keeps the reported results.
        if (!cmd_arm_adc) begin
            state_d     = ST_IDLE;
            sample_en_d = 1'b0;
            len_run_d   = 1'b0;
            seg_cnt_d   = seg_cnt_q;
            trig_len_d  = trig_len_q;
        end

        capturing_d = (state_d == ST_OFFSET) || (state_d == ST_CAPTURE) ||
                      (state_d == ST_SEG_WAIT);
        armed_d     = (state_d == ST_WAIT_IDLE) || (state_d == ST_ARMED);
        done_d      = (state_d == ST_DONE);
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge adc_sampleclk) begin
        if (reset_i) begin
            state_q       <= ST_IDLE;
            trig_r_q      <= 1'b0;
            rearm_ok_q    <= 1'b0;
            offset_q      <= '0;
            maxs_q        <= '0;
            ds_q          <= '0;
            off_cnt_q     <= '0;
            ds_cnt_q      <= '0;
            samp_cnt_q    <= '0;
            seg_timer_q   <= '0;
            seg_cnt_q     <= '0;
            trig_len_q    <= '0;
            len_run_q     <= 1'b0;
            len_started_q <= 1'b0;
            sample_en_q   <= 1'b0;
            capturing_q   <= 1'b0;
            armed_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            trig_r_q      <= trig_r_d;
            rearm_ok_q    <= rearm_ok_d;
            offset_q      <= offset_d;
            maxs_q        <= maxs_d;
            ds_q          <= ds_d;
            off_cnt_q     <= off_cnt_d;
            ds_cnt_q      <= ds_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            seg_timer_q   <= seg_timer_d;
            seg_cnt_q     <= seg_cnt_d;
            trig_len_q    <= trig_len_d;
            len_run_q     <= len_run_d;
            len_started_q <= len_started_d;
            sample_en_q   <= sample_en_d;
            capturing_q   <= capturing_d;
            armed_q       <= armed_d;
            done_q        <= done_d;
        end
    end

    // The strobe is suppressed in the very cycle arm drops.
    assign sample_en      = sample_en_q & cmd_arm_adc;
    assign capturing      = capturing_q;
    assign armed          = armed_q;
    assign capture_done   = done_q;
    assign segment_count  = seg_cnt_q;
    assign trigger_length = trig_len_q;

endmodule
